mux_scan_ctrl: RTL and testbench
================================

MUX_SCAN_CTRL -- requirements
Module: mux_scan_ctrl

Interface
REQ-001 Parameter DWELL, default 2: settle cycles per channel before y is sampled; legal range 1..15.
REQ-002 clk  input  1  single clock, rising-edge active.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request one scan frame; sampled in IDLE only.
REQ-005 auto  input  1  when 1, a new frame starts automatically after each accepted frame.
REQ-006 ch_en  input  4  channel enable mask; bit i enables mux input i (0=a, 1=b, 2=c, 3=d).
REQ-007 y  input  1  output of the downstream 4x1 mux.
REQ-008 out_ready  input  1  consumer accepts the frame.
REQ-009 sel  output  2  select driven to the 4x1 mux.
REQ-010 busy  output  1  high in SETTLE, SAMPLE and DONE.
REQ-011 frame  output  4  sampled y per channel; bit i holds channel i.
REQ-012 frame_valid  output  1  frame complete and stable.

Function
REQ-013 FSM states SHALL be IDLE, SETTLE, SAMPLE and DONE, with registered outputs only.
REQ-014 IDLE: start=1 with ch_en!=0 at an edge SHALL latch ch_en into an internal mask, clear frame, set sel to the lowest enabled index, load dwell count 0, and go to SETTLE.
REQ-015 IDLE with start=1 and ch_en=0 SHALL be ignored: stay IDLE, busy=0.
REQ-016 SETTLE SHALL hold sel for exactly DWELL cycles, then go to SAMPLE.
REQ-017 SAMPLE SHALL last 1 cycle; at its closing edge it SHALL write y into frame[sel].
REQ-018 At that same edge, SAMPLE SHALL set sel to the next higher enabled index and go to SETTLE; if no higher index is enabled, it SHALL go to DONE with frame_valid=1.
REQ-019 Each enabled channel costs DWELL+1 cycles; frame_valid SHALL rise N*(DWELL+1) edges after the start edge (N = enabled channel count).
REQ-020 Disabled channels SHALL never appear on sel during a scan, and their frame bits SHALL read 0.
REQ-021 ch_en and start changes during a scan SHALL be ignored; only the latched mask is used.
REQ-022 DONE: frame and frame_valid SHALL hold while out_ready=0.
REQ-023 DONE with out_ready=1: frame_valid SHALL drop at the next edge, and frame SHALL keep its value until the next frame start.
REQ-024 On leaving DONE with auto=1 and the live ch_en!=0, the FSM SHALL start a new frame directly, as in REQ-014; otherwise it SHALL return to IDLE.
REQ-025 In IDLE, sel SHALL remain at its last value.
REQ-026 The dwell counter SHALL be 4 bits and SHALL never wrap within a state.

Reset
REQ-027 rst_n=0 SHALL force, asynchronously and regardless of state (including mid-scan): IDLE, sel=2'b00, busy=0, frame=4'b0000, frame_valid=0, mask=0, dwell count 0.
REQ-028 The first start SHALL be honoured on the first rising edge after rst_n deasserts.

Verification
REQ-029 DWELL=2, mux a=0 b=1 c=0 d=1, ch_en=1111, start pulse, out_ready=1 -> sel 00,01,10,11 each for 3 cycles; frame_valid at edge 12; frame=4'b1010.
REQ-030 a=1 b=0 c=1 d=0, ch_en=0101 -> sel visits only 00 and 10; frame=4'b0101; frame_valid at edge 6.
REQ-031 start with ch_en=0000 -> busy, sel and frame_valid unchanged for 10 cycles.
REQ-032 out_ready=0 for 5 cycles in DONE, with start and ch_en toggled meanwhile -> frame and frame_valid stable; drop 1 cycle after out_ready=1.
REQ-033 rst_n pulsed low mid-SETTLE of channel 2 -> immediate sel=00, busy=0, frame=0000; the next start scans normally.
REQ-034 auto=1, ch_en=1111, out_ready=1 -> back-to-back frames, each frame_valid pulse 13 cycles apart, with no IDLE cycle between.

Source files
------------

// File: rtl/mux_scan_ctrl_if.sv
// Bundles the scan controller's control, mux feedback and frame handoff signals.
// The master side drives requests and the mux output; the slave side is the controller.
interface mux_scan_ctrl_if;
   logic       start;
   logic       auto;
   logic [3:0] ch_en;
   logic       y;
   logic       out_ready;
   logic [1:0] sel;
   logic       busy;
   logic [3:0] frame;
   logic       frame_valid;

   modport master (
      output start, auto, ch_en, y, out_ready,
      input  sel, busy, frame, frame_valid
   );

   modport slave (
      input  start, auto, ch_en, y, out_ready,
      output sel, busy, frame, frame_valid
   );
endinterface

// File: rtl/mux_scan_ctrl.sv
// Steps a 4x1 mux select through the enabled channels, lets each settle for DWELL
// cycles, samples the mux output into a frame and hands the frame to a consumer.
module mux_scan_ctrl #(
   parameter int unsigned DWELL = 2
) (
   input  logic           clk,
   input  logic           rst_n,
   mux_scan_ctrl_if.slave bus
);

   typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

   localparam logic [3:0] DWELL_LAST = 4'(DWELL - 1);

   state_t     state, state_next;
   logic [1:0] sel_q, sel_next;
   logic [3:0] mask, mask_next;
   logic [3:0] frame_q, frame_next;
   logic [3:0] dwell_cnt, dwell_next;
   logic       busy_q, busy_next;
   logic       valid_q, valid_next;
   logic       launch;
   logic       more_after_sel;
   logic [2:0] sel_plus_one;

   function automatic logic any_from(input logic [3:0] m, input logic [2:0] from);
      logic found;
      found = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (i >= int'(from) && m[i]) found = 1'b1;
      end
      return found;
   endfunction

   function automatic logic [1:0] first_from(input logic [3:0] m, input logic [2:0] from);
      logic [1:0] idx;
      idx = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (i >= int'(from) && m[i]) idx = 2'(i);
      end
      return idx;
   endfunction

   // A frame starts either from IDLE on request or straight out of DONE in auto mode.
   assign launch = (bus.ch_en != 4'b0000) &&
                   ((state == IDLE && bus.start) ||
                    (state == DONE && bus.out_ready && bus.auto));

   assign sel_plus_one   = {1'b0, sel_q} + 3'd1;
   assign more_after_sel = any_from(mask, sel_plus_one);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         sel_q     <= 2'b00;
         mask      <= 4'b0000;
         frame_q   <= 4'b0000;
         dwell_cnt <= 4'd0;
         busy_q    <= 1'b0;
         valid_q   <= 1'b0;
      end else begin
         state     <= state_next;
         sel_q     <= sel_next;
         mask      <= mask_next;
         frame_q   <= frame_next;
         dwell_cnt <= dwell_next;
         busy_q    <= busy_next;
         valid_q   <= valid_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:   if (launch) state_next = SETTLE;
         SETTLE: if (dwell_cnt == DWELL_LAST) state_next = SAMPLE;
         SAMPLE: state_next = more_after_sel ? SETTLE : DONE;
         DONE:   if (bus.out_ready) state_next = launch ? SETTLE : IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Outputs are computed from the upcoming state so they leave the register together with it.
   always_comb begin
      sel_next   = sel_q;
      mask_next  = mask;
      frame_next = frame_q;
      dwell_next = dwell_cnt;
      busy_next  = (state_next != IDLE);
      valid_next = (state_next == DONE);
      if (launch) begin
         mask_next  = bus.ch_en;
         frame_next = 4'b0000;
         sel_next   = first_from(bus.ch_en, 3'd0);
         dwell_next = 4'd0;
      end else begin
         case (state)
            SETTLE: dwell_next = (dwell_cnt == DWELL_LAST) ? 4'd0 : dwell_cnt + 4'd1;
            SAMPLE: begin
               frame_next[sel_q] = bus.y;
               dwell_next        = 4'd0;
               if (more_after_sel) sel_next = first_from(mask, sel_plus_one);
            end
            default: ;
         endcase
      end
   end

   assign bus.sel         = sel_q;
   assign bus.busy        = busy_q;
   assign bus.frame       = frame_q;
   assign bus.frame_valid = valid_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Randomized bench for mux_scan_ctrl; expected select sequences, frames and timing
// come from the channel list of each scan rather than from the controller's states.
module tb_mux_scan_ctrl;

   localparam int DWELL = 2;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] mux_in;
   int         checks = 0;
   int         errors = 0;

   mux_scan_ctrl_if bus();

   assign bus.y = mux_in[bus.sel];

   mux_scan_ctrl #(.DWELL(DWELL)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One full scan: each enabled channel, lowest first, owns DWELL+1 cycles of sel.
   task automatic run_frame(input logic [3:0] en, input logic [3:0] mux, input int hold, input bit noisy);
      int         seq[$];
      logic [3:0] exp_frame;
      int         last_ch;
      for (int i = 0; i < 4; i++)
         if (en[i]) repeat (DWELL + 1) seq.push_back(i);
      exp_frame     = mux & en;
      last_ch       = seq[$];
      mux_in        = mux;
      bus.ch_en     = en;
      bus.start     = 1'b1;
      bus.out_ready = 1'b0;
      tick();
      bus.start = 1'b0;
      foreach (seq[k]) begin
         if (k == 0) check_output("scan_clear", bus.frame, 0);
         check_output("scan_sel", bus.sel, seq[k]);
         check_output("scan_busy", bus.busy, 1);
         check_output("scan_valid", bus.frame_valid, 0);
         if (noisy) begin
            bus.ch_en = 4'($urandom);
            bus.start = 1'($urandom);
         end
         tick();
      end
      check_output("done_valid", bus.frame_valid, 1);
      check_output("done_frame", bus.frame, exp_frame);
      check_output("done_busy", bus.busy, 1);
      repeat (hold) begin
         bus.start = 1'($urandom);
         bus.ch_en = 4'($urandom);
         tick();
         check_output("hold_valid", bus.frame_valid, 1);
         check_output("hold_frame", bus.frame, exp_frame);
      end
      bus.start     = 1'b0;
      bus.out_ready = 1'b1;
      tick();
      check_output("drop_valid", bus.frame_valid, 0);
      check_output("drop_busy", bus.busy, 0);
      check_output("drop_frame", bus.frame, exp_frame);
      bus.out_ready = 1'b0;
      tick();
      tick();
      check_output("idle_sel", bus.sel, last_ch);
      check_output("idle_frame", bus.frame, exp_frame);
   endtask

   initial begin
      int         n;
      int         rises[$];
      logic       prev_valid;
      logic [3:0] m;

      bus.start     = 1'b0;
      bus.auto      = 1'b0;
      bus.ch_en     = 4'b0000;
      bus.out_ready = 1'b0;
      mux_in        = 4'b0000;
      rst_n         = 1'b1;
      #2 rst_n = 1'b0;
      #10;
      check_output("rst_sel", bus.sel, 0);
      check_output("rst_busy", bus.busy, 0);
      check_output("rst_frame", bus.frame, 0);
      check_output("rst_valid", bus.frame_valid, 0);
      @(negedge clk) rst_n = 1'b1;

      // Mux a=0 b=1 c=0 d=1, then a=1 b=0 c=1 d=0 with only a and c enabled.
      run_frame(4'b1111, 4'b1010, 0, 1'b0);
      run_frame(4'b0101, 4'b0101, 5, 1'b1);

      bus.ch_en = 4'b0000;
      bus.start = 1'b1;
      repeat (10) begin
         tick();
         check_output("nostart_busy", bus.busy, 0);
         check_output("nostart_sel", bus.sel, 2);
         check_output("nostart_valid", bus.frame_valid, 0);
      end
      bus.start = 1'b0;

      for (int r = 0; r < 10; r++)
         run_frame(4'($urandom_range(1, 15)), 4'($urandom), $urandom_range(0, 5), 1'b1);

      mux_in    = 4'b1111;
      bus.ch_en = 4'b1111;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      n = 0;
      while (bus.sel != 2'd2 && n < 20) begin
         tick();
         n++;
      end
      check_output("wait_sel2", bus.sel, 2);
      #2 rst_n = 1'b0;
      #1;
      check_output("midrst_sel", bus.sel, 0);
      check_output("midrst_busy", bus.busy, 0);
      check_output("midrst_frame", bus.frame, 0);
      check_output("midrst_valid", bus.frame_valid, 0);
      @(negedge clk) rst_n = 1'b1;
      run_frame(4'b1110, 4'($urandom), 1, 1'b0);

      // Auto mode: each frame restarts on the edge that accepts the previous one.
      m             = 4'($urandom);
      mux_in        = m;
      bus.auto      = 1'b1;
      bus.out_ready = 1'b1;
      bus.ch_en     = 4'b1111;
      bus.start     = 1'b1;
      tick();
      bus.start  = 1'b0;
      prev_valid = 1'b0;
      for (int c = 0; c < 60 && rises.size() < 3; c++) begin
         check_output("auto_busy", bus.busy, 1);
         if (bus.frame_valid && !prev_valid) begin
            rises.push_back(c);
            check_output("auto_frame", bus.frame, m);
         end
         prev_valid = bus.frame_valid;
         tick();
      end
      check_output("auto_count", rises.size(), 3);
      foreach (rises[i]) check_output("auto_rise", rises[i], 12 + 13 * i);
      bus.auto = 1'b0;
      n = 0;
      while (bus.busy && n < 60) begin
         tick();
         n++;
      end
      check_output("auto_stop", bus.busy, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
